// File: rtl/alu8_op_sequencer.sv
// alu8_op_sequencer: valid/ready sequencer for logic/add/sub/shift ops and a shift-add multiply
module alu8_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_z,
  output logic                 out_c,
  output logic                 out_n,
  output logic                 out_v,
  output logic                 busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, lo;
  logic [WIDTH:0] sum, dif;
  logic [2*WIDTH-1:0] shl, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic c_nx, v_nx, last;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    shl = {{WIDTH{1'b0}}, a} << b[SW-1:0];
    lo = op == 3'd0 ? a & b :
         op == 3'd1 ? a | b :
         op == 3'd2 ? a ^ b :
         op == 3'd3 ? ~a :
         op == 3'd4 ? sum[WIDTH-1:0] :
         op == 3'd5 ? dif[WIDTH-1:0] : shl[WIDTH-1:0];
    c_nx = op == 3'd4 ? sum[WIDTH] :
           op == 3'd5 ? dif[WIDTH] :
           op == 3'd6 ? (b[SW-1:0] != '0) && shl[WIDTH] : 1'b0;
    v_nx = op == 3'd4 ? (a[WIDTH-1] == b[WIDTH-1]) && (lo[WIDTH-1] != a[WIDTH-1]) :
           op == 3'd5 ? (a[WIDTH-1] != b[WIDTH-1]) && (lo[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    acc_nx = acc + (b[cnt[SW-1:0]] ? {{WIDTH{1'b0}}, a} << cnt[SW-1:0] : '0);
    last = cnt == CW'(WIDTH - 1);
    state_nx = state == IDLE ? (in_valid ? (in_op == 3'd7 ? MUL : EXEC) : IDLE) :
               state == EXEC ? DONE :
               state == MUL  ? (last ? DONE : MUL) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
      out_result <= '0;
      out_z <= 1'b0;
      out_c <= 1'b0;
      out_n <= 1'b0;
      out_v <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        op <= in_op;
        a <= in_a;
        b <= in_b;
        acc <= '0;
        cnt <= '0;
      end
      if (state == EXEC) begin
        out_result <= {{WIDTH{1'b0}}, lo};
        out_z <= lo == '0;
        out_c <= c_nx;
        out_n <= lo[WIDTH-1];
        out_v <= v_nx;
      end
      if (state == MUL) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          out_result <= acc_nx;
          out_z <= acc_nx == '0;
          out_c <= |acc_nx[2*WIDTH-1:WIDTH];
          out_n <= acc_nx[2*WIDTH-1];
          out_v <= 1'b0;
        end
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == EXEC || state == MUL;
endmodule

// File: tb/tb_alu8_op_sequencer.sv
// tb_alu8_op_sequencer: directed and random ops checked against an arithmetic reference model
module tb_alu8_op_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_z, out_c, out_n, out_v, busy;
  logic [2:0] in_op = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic [15:0] out_result;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  alu8_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_z(out_z), .out_c(out_c), .out_n(out_n), .out_v(out_v),
    .busy(busy)
  );
  function automatic logic [19:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r = 0, s = 0, sh = b % 8;
    logic c = 0, v = 0, z, n;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: r = 255 - ua;
      3'd4: begin r = ua + ub; c = r > 255; s = sa + sb; v = s > 127 || s < -128; r = r % 256; end
      3'd5: begin c = ua < ub; s = sa - sb; v = s > 127 || s < -128; r = (ua - ub + 256) % 256; end
      3'd6: begin r = (ua << sh) % 256; c = sh != 0 && ((ua >> (8 - sh)) % 2) == 1; end
      default: begin r = ua * ub; c = r > 255; end
    endcase
    n = op == 3'd7 ? r[15] : r[7];
    z = r == 0;
    return {r[15:0], z, c, n, v};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int stall, input string tag);
    logic [19:0] e;
    int lat;
    e = model(op, a, b);
    check({tag, "_rdy"}, 32'(in_ready), 1);
    in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
    check({tag, "_busy"}, 32'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, lat, op == 3'd7 ? 8 : 1);
    for (int i = 0; i <= stall; i++) begin
      check({tag, "_res"}, 32'(out_result), 32'(e[19:4]));
      check({tag, "_flags"}, {out_z, out_c, out_n, out_v}, 32'(e[3:0]));
      if (i < stall) @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
  endtask
  initial begin
    logic [19:0] e;
    @(posedge clk);
    @(negedge clk);
    check("rst_out", {in_ready, out_valid, busy, out_z, out_c, out_n, out_v}, 7'b1000000);
    check("rst_res", 32'(out_result), 0);
    rst = 0;
    @(negedge clk);
    run_op(3'd0, 8'hF0, 8'h3C, 0, "and");
    run_op(3'd4, 8'hFF, 8'h01, 0, "add_carry");
    run_op(3'd4, 8'h7F, 8'h01, 0, "add_ovf");
    run_op(3'd5, 8'h05, 8'h07, 0, "sub_borrow");
    run_op(3'd6, 8'h81, 8'h01, 0, "shl");
    run_op(3'd6, 8'h81, 8'h08, 0, "shl_zero");
    run_op(3'd3, 8'h00, 8'h00, 0, "not");
    run_op(3'd7, 8'hFF, 8'hFF, 0, "mul_max");
    run_op(3'd7, 8'h00, 8'h37, 0, "mul_zero");
    e = model(3'd0, 8'hA5, 8'h0F);
    in_valid = 1; in_op = 3'd0; in_a = 8'hA5; in_b = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    in_valid = 1; in_op = 3'd4; in_a = 8'h01; in_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check("bp_state", {in_ready, out_valid}, 2'b01);
      check("bp_res", 32'(out_result), 32'(e[19:4]));
      check("bp_flags", {out_z, out_c, out_n, out_v}, 32'(e[3:0]));
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("bp_idle", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    in_valid = 0;
    check("bp_accept", {in_ready, busy}, 2'b01);
    @(negedge clk);
    check("bp_queued", {out_valid, 16'(out_result)}, {1'b1, 16'h0002});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    in_valid = 1; in_op = 3'd7; in_a = 8'hAB; in_b = 8'hCD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_out", {in_ready, out_valid, busy, out_z, out_c, out_n, out_v}, 7'b1000000);
    check("abort_res", 32'(out_result), 0);
    run_op(3'd4, 8'h02, 8'h03, 0, "post_abort");
    for (int k = 0; k < 60; k++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
